// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider for the DIV/DIVU path.
// Returns {remainder, quotient} 33 cycles after accept, with flush (annul) support.
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    localparam int unsigned DW    = 32;
    localparam int unsigned RW    = 64;
    localparam int unsigned WW    = 65;
    localparam int unsigned CW    = 6;
    localparam int unsigned ITERS = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [WW-1:0]   work, work_nxt;
    logic [DW-1:0]   divisor, divisor_nxt;
    logic            neg_q, neg_q_nxt;
    logic            neg_r, neg_r_nxt;
    logic [RW-1:0]   result_nxt;
    logic            ready_nxt;

    logic [DW:0]     diff;
    logic [DW-1:0]   abs_a;
    logic [DW-1:0]   abs_b;
    logic [DW-1:0]   q_fix;
    logic [DW-1:0]   r_fix;
    logic            go;

    assign stallreq_o = start_i & ~annul_i & ~ready_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            work     <= work_nxt;
            divisor  <= divisor_nxt;
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
        end
    end

    // Operand conditioning, trial subtraction and final sign fix-up
    always_comb begin
        go    = start_i & ~annul_i;
        abs_a = (signed_div_i && opdata1_i[DW-1]) ? (~opdata1_i + DW'(1)) : opdata1_i;
        abs_b = (signed_div_i && opdata2_i[DW-1]) ? (~opdata2_i + DW'(1)) : opdata2_i;
        diff  = {1'b0, work[63:32]} - {1'b0, divisor};
        q_fix = neg_q ? (~work[31:0] + DW'(1)) : work[31:0];
        r_fix = neg_r ? (~work[64:33] + DW'(1)) : work[64:33];
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        work_nxt    = work;
        divisor_nxt = divisor;
        neg_q_nxt   = neg_q;
        neg_r_nxt   = neg_r;
        result_nxt  = result_o;
        ready_nxt   = ready_o;

        case (state)
            S_IDLE: begin
                if (go) begin
                    if (opdata2_i == '0) begin
                        state_nxt = S_BYZERO;
                    end else begin
                        state_nxt   = S_ON;
                        cnt_nxt     = '0;
                        work_nxt    = {32'b0, abs_a, 1'b0};
                        divisor_nxt = abs_b;
                        neg_q_nxt   = signed_div_i & (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
                        neg_r_nxt   = signed_div_i & opdata1_i[DW-1];
                    end
                end
            end
            S_BYZERO: begin
                if (!go) begin
                    state_nxt  = S_IDLE;
                    result_nxt = '0;
                    ready_nxt  = 1'b0;
                end else begin
                    state_nxt  = S_END;
                    result_nxt = '0;
                    ready_nxt  = 1'b1;
                end
            end
            S_ON: begin
                // Annul/withdraw wins even on the final (cnt==32) edge
                if (!go) begin
                    state_nxt  = S_IDLE;
                    result_nxt = '0;
                    ready_nxt  = 1'b0;
                end else if (cnt != CW'(ITERS)) begin
                    if (diff[DW]) begin
                        work_nxt = {work[63:0], 1'b0};
                    end else begin
                        work_nxt = {diff[31:0], work[31:0], 1'b1};
                    end
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    state_nxt  = S_END;
                    result_nxt = {r_fix, q_fix};
                    ready_nxt  = 1'b1;
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_nxt  = S_IDLE;
                    result_nxt = '0;
                    ready_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed table, random vectors vs. an
// arithmetic reference model, and annul/reset/withdraw corner sequences.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_vec = 0;
    int n_err = 0;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: magnitude divide with plain integer arithmetic, then apply signs
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ma, mb, q, r;
        if (b == 0) return 64'h0;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        q  = ma / mb;
        r  = ma % mb;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    // Full handshake: accept, wait for ready (bounded), check, hold, release
    task automatic run_div(input string name, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        int edges, stall_cnt, exp_lat;
        bit got_ready;
        exp_lat   = (b == 0) ? 1 : 33;
        stall_cnt = 0;
        got_ready = 0;
        edges     = 0;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        #1;
        chk({name, " stall_at_req"}, 64'(stallreq_o), 64'h1);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_div_i = 1'($urandom);
            if (ready_o) begin
                got_ready = 1;
                break;
            end
            edges++;
            if (stallreq_o) stall_cnt++;
        end
        if (!got_ready) begin
            chk({name, " timeout"}, 64'h0, 64'h1);
        end else begin
            chk({name, " latency"}, 64'(edges), 64'(exp_lat));
            chk({name, " stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
            chk({name, " stall_drop"}, 64'(stallreq_o), 64'h0);
            chk({name, " result"}, result_o, exp);
            @(negedge clk);
            chk({name, " hold"}, {63'h0, ready_o} ^ result_o, {63'h0, 1'b1} ^ exp);
        end
        start_i = 1'b0;
        @(negedge clk);
        chk({name, " release"}, {63'h0, ready_o} | result_o, 64'h0);
    endtask

    vec_t tbl[8];
    logic [63:0] exp_v;

    initial begin
        tbl[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
        tbl[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD};
        tbl[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
        tbl[3] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};
        tbl[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
        tbl[5] = '{1'b0, 32'd12345,      32'd0,          64'h0};
        tbl[6] = '{1'b1, 32'hFFFFFF00,   32'd0,          64'h0};
        tbl[7] = '{1'b0, 32'd5,          32'd9,          64'h00000005_00000000};

        #12;
        chk("reset_outputs", {63'h0, ready_o} | result_o, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_div($sformatf("tbl%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp_res);
        end

        for (int i = 0; i < 30; i++) begin
            bit sgn;
            logic [31:0] a, b;
            sgn = 1'($urandom);
            a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 16));
                2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                default: b = 32'($urandom);
            endcase
            run_div($sformatf("rnd%0d", i), sgn, a, b, model(sgn, a, b));
        end

        // Annul in the middle of iterations: no result, IDLE blocked while annul held
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        #1;
        chk("annul stall_low", 64'(stallreq_o), 64'h0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o) begin
                chk("annul no_ready", 64'(ready_o), 64'h0);
                break;
            end
        end
        chk("annul result_zero", result_o, 64'h0);
        annul_i = 1'b0; start_i = 1'b0;
        run_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        // Annul asserted before accept holds the block in IDLE
        @(negedge clk);
        opdata1_i = 32'd77; opdata2_i = 32'd0; start_i = 1'b1; annul_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_annul blocked", {63'h0, ready_o} | {63'h0, stallreq_o}, 64'h0);
        start_i = 1'b0; annul_i = 1'b0;

        // Withdraw start during BYZERO: nothing is produced
        @(negedge clk);
        opdata1_i = 32'd4; opdata2_i = 32'd0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("byzero_withdraw", {63'h0, ready_o} | result_o, 64'h0);
        end

        // Asynchronous reset mid-divide, then a clean divide
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (21) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_on", {63'h0, ready_o} | result_o, 64'h0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div("after_rst", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A);

        // Asynchronous reset while a result is held clears it without a clock edge
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ready_o) break;
        end
        chk("end_before_rst", result_o, 64'h00000000_0000000A);
        #2 rst = 1'b0;
        #1;
        chk("rst_in_end", {63'h0, ready_o} | result_o, 64'h0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
